irq_controller: RTL and testbench
=================================

# irq_controller

Memory-mapped interrupt controller that arbitrates the processor's interrupt sources and sequences delivery to the single-cycle core. Sources include the peripheral timer, UART send-done and spare lines. The block latches and masks the sources and picks the highest-priority one. It raises one interrupt request, holds it until the core enters kernel mode (PC[31]=1), then keeps that source in service until software writes EOI. It sits on the data bus beside the peripheral block at 0x40000030–0x4000003C, and its read data is ORed into the memory read mux.

## Interface
- NSRC, 4: number of interrupt sources, 1..8; index 0 is highest priority.
- BASE, 32'h40000030: byte address of register 0.
- sysclk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- src  in  NSRC  interrupt source lines, sysclk-synchronous (src[0]=timer, src[1]=uart_send).
- in_kernel  in  1  core PC[31].
- mem_rd  in  1  bus read strobe.
- mem_wr  in  1  bus write strobe, one sysclk per access.
- addr  in  32  bus byte address.
- wdata  in  32  bus write data.
- rdata  out  32  combinational read data; 0 when not selected or mem_rd=0.
- irq  out  1  interrupt request to core, registered.

## Operation
- Selected when addr[31:4]==BASE[31:4]; register index is addr[3:2].
- Register 0, PENDING: RO in level mode. W1C on bits [NSRC-1:0] in edge mode.
- Register 1, MASK: RW on bits [NSRC-1:0]. A 1 enables the source. Reset value is 0.
- Register 2, VECTOR: RO. Bit 31 = in service, bits [2:0] = active index, all other bits 0.
- Register 3, EOI: WO. Any write ends service. Reads return 0.
- eligible = pending & mask. The winner is the lowest set index of eligible.
- States:
  - IDLE, irq=0. If eligible≠0 and in_kernel=0: latch the winner into act_id and go to REQ.
  - REQ, irq=1. If in_kernel=1, go to SVC. If mask[act_id]=0 or pending[act_id]=0 (request withdrawn), go to IDLE.
  - SVC, irq=0 and VECTOR[31]=1. On an EOI write: clear pending[act_id] (edge mode only) and go to IDLE. If in_kernel falls with no EOI, go to IDLE and leave pending unchanged.
- act_id is stable from REQ entry until IDLE is re-entered. A higher-priority arrival during REQ or SVC does not preempt; it is taken on the next IDLE→REQ pass.
- EOI written in IDLE or REQ is ignored.

## Timing
- Reset values: irq=0, state IDLE, pending=0, mask=0, act_id=0, src_q=0. rdata=0 follows from the reset state.
- src is registered into src_q. A source that rises at edge n sets pending at n+1. The FSM enters REQ and irq=1 at n+2.
- in_kernel high sampled at edge k means state=SVC and irq=0 after k.
- An EOI write at edge k means state=IDLE after k. A still-eligible source re-raises irq after k+1 at the earliest.
- Writes take effect on the sysclk edge where mem_wr=1. Reads are combinational from current state.
- Same-cycle edge set and W1C on the same bit: set wins.
- reset asserted mid-REQ or mid-SVC: everything returns to reset values immediately, and irq drops asynchronously.

## Configuration
- IRQ_EDGE_EN defined:
  - pending[i] sets on a rising edge of src (src & ~src_q) and holds until W1C or EOI of that source.
- IRQ_EDGE_EN undefined:
  - pending = src_q (level mode); W1C writes are ignored.
  - EOI clears nothing; a source is deasserted by servicing the peripheral.

## Structure
- Package irq_pkg holds:
  - register index constants REG_PENDING=0, REG_MASK=1, REG_VECTOR=2, REG_EOI=3;
  - FSM state encoding IDLE/REQ/SVC as a 2-bit enum;
  - the maximum NSRC (8).
- Sub-module irq_prio_enc: parameterised combinational lowest-index priority encoder that outputs valid and index[2:0].
- Top level holds the bus decode, the pending/mask registers and the FSM.

## Test plan
- Reset, then write MASK=4'b0011. Pulse src[1] for one cycle (edge mode) → irq=1 two edges later. Raise in_kernel → irq=0 and VECTOR reads 32'h80000001. Write EOI → PENDING reads 0 and VECTOR reads 0.
- Raise src[0] and src[2] in the same cycle with MASK=4'b0101 → act_id=0. After the EOI, irq re-asserts with act_id=2.
- In REQ with act_id=1, write MASK=0 → irq=0 on the next edge and the FSM is back in IDLE. PENDING still reads 4'b0010.
- In SVC, src[0] rises (higher priority) → irq stays 0 until EOI. Then irq=1 with act_id=0.
- Write PENDING=4'b0001 in the same cycle that src[0] has a new rising edge → PENDING bit 0 reads 1 afterwards (set wins).
- Assert reset while in SVC → irq=0, MASK=0, PENDING=0 and VECTOR=0 with no clock edge required.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller: register map indices,
// FSM state encoding and the upper bound on the number of sources.
package irq_pkg;

    localparam int NSRC_MAX = 8;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder; index 0 has the highest priority.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [2:0]   o_index
);

    always_comb begin
        o_valid = |i_req;
        o_index = 3'd0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches/masks sources, requests the core and holds
// the winner in service until EOI. Define IRQ_EDGE_EN for edge-latched pending (default: level).
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'h40000030
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            in_kernel,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    logic [NSRC-1:0]     r_src_q;
    logic [NSRC-1:0]     r_mask;
    logic [NSRC-1:0]     w_pending;
    logic [NSRC-1:0]     w_eligible;
    logic [NSRC_MAX-1:0] w_mask_ext;
    logic [NSRC_MAX-1:0] w_pend_ext;

    irq_state_e          r_state;
    irq_state_e          w_state_next;
    logic [2:0]          r_act_id;
    logic [2:0]          w_act_next;
    logic                r_irq;

    logic                w_sel;
    logic [1:0]          w_idx;
    logic                w_wr_pend;
    logic                w_wr_mask;
    logic                w_wr_eoi;
    logic                w_eoi_clr;
    logic                w_win_valid;
    logic [2:0]          w_win_id;
    logic                w_unused;

    assign w_sel     = (addr[31:4] == BASE[31:4]);
    assign w_idx     = addr[3:2];
    assign w_wr_pend = w_sel && mem_wr && (w_idx == REG_PENDING);
    assign w_wr_mask = w_sel && mem_wr && (w_idx == REG_MASK);
    assign w_wr_eoi  = w_sel && mem_wr && (w_idx == REG_EOI);

    assign w_unused  = ^{addr[1:0], wdata[31:NSRC], w_wr_pend, w_eoi_clr};

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_src_q <= '0;
            r_mask  <= '0;
        end else begin
            r_src_q <= src;
            if (w_wr_mask) begin
                r_mask <= wdata[NSRC-1:0];
            end
        end
    end

`ifdef IRQ_EDGE_EN
    logic [NSRC-1:0]     r_pending;
    logic [NSRC-1:0]     w_clr;
    logic [NSRC_MAX-1:0] w_act_onehot;

    assign w_act_onehot = NSRC_MAX'(1) << r_act_id;
    assign w_clr = (w_wr_pend ? wdata[NSRC-1:0] : '0)
                 | (w_eoi_clr ? w_act_onehot[NSRC-1:0] : '0);

    // A fresh rising edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | (src & ~r_src_q);
        end
    end

    assign w_pending = r_pending;
`else
    assign w_pending = r_src_q;
`endif

    assign w_eligible = w_pending & r_mask;
    assign w_mask_ext = NSRC_MAX'(r_mask);
    assign w_pend_ext = NSRC_MAX'(w_pending);

    irq_prio_enc #(
        .N (NSRC)
    ) u_prio_enc (
        .i_req   (w_eligible),
        .o_valid (w_win_valid),
        .o_index (w_win_id)
    );

    always_comb begin
        w_state_next = r_state;
        w_act_next   = r_act_id;
        w_eoi_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid && !in_kernel) begin
                    w_state_next = REQ;
                    w_act_next   = w_win_id;
                end
            end
            REQ: begin
                if (in_kernel) begin
                    w_state_next = SVC;
                end else if (!w_mask_ext[r_act_id] || !w_pend_ext[r_act_id]) begin
                    w_state_next = IDLE;
                end
            end
            SVC: begin
                if (w_wr_eoi) begin
                    w_state_next = IDLE;
                    w_eoi_clr    = 1'b1;
                end else if (!in_kernel) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_act_id <= 3'd0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_act_id <= w_act_next;
            r_irq    <= (w_state_next == REQ);
        end
    end

    assign irq = r_irq;

    // The vector index is only meaningful while a source is requested or in service.
    always_comb begin
        rdata = '0;
        if (w_sel && mem_rd) begin
            case (w_idx)
                REG_PENDING: rdata[NSRC-1:0] = w_pending;
                REG_MASK:    rdata[NSRC-1:0] = r_mask;
                REG_VECTOR: begin
                    rdata[31]  = (r_state == SVC);
                    rdata[2:0] = (r_state == IDLE) ? 3'd0 : r_act_id;
                end
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: behavioural model compared every cycle plus
// directed scenarios with literal expectations. Works with or without IRQ_EDGE_EN.
module tb_irq_controller;

`ifdef IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    localparam logic [31:0] BASE_A = 32'h40000030;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SVC  = 2;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic [3:0]  src    = 4'b0;
    logic        in_kernel = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(
        .NSRC (4),
        .BASE (BASE_A)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .src       (src),
        .in_kernel (in_kernel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq)
    );

    always #10 sysclk = ~sysclk;

    // ---------------- behavioural model ----------------
    logic [3:0] m_src_q, m_pend, m_mask;
    int         m_phase, m_act;
    logic       m_irq;
    logic [3:0] t_pend, t_elig, t_clr;
    int         t_ph, t_act;
    logic [1:0] t_idx;
    bit         t_wr;

    function automatic int lowest_set(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] model_pending();
        return EDGE ? m_pend : m_src_q;
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = 32'h0;
        if (addr[31:4] == BASE_A[31:4] && mem_rd) begin
            case (addr[3:2])
                2'd0: r = {28'h0, model_pending()};
                2'd1: r = {28'h0, m_mask};
                2'd2: begin
                    r[31] = (m_phase == P_SVC);
                    if (m_phase != P_IDLE) r[2:0] = m_act[2:0];
                end
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    always @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            m_src_q <= 4'b0;
            m_pend  <= 4'b0;
            m_mask  <= 4'b0;
            m_phase <= P_IDLE;
            m_act   <= 0;
            m_irq   <= 1'b0;
        end else begin
            t_pend = model_pending();
            t_elig = t_pend & m_mask;
            t_idx  = addr[3:2];
            t_wr   = (addr[31:4] == BASE_A[31:4]) && mem_wr;
            t_ph   = m_phase;
            t_act  = m_act;
            t_clr  = 4'b0;
            if (m_phase == P_IDLE) begin
                if (t_elig != 4'b0 && !in_kernel) begin
                    t_ph  = P_REQ;
                    t_act = lowest_set(t_elig);
                end
            end else if (m_phase == P_REQ) begin
                if (in_kernel) t_ph = P_SVC;
                else if (!m_mask[m_act] || !t_pend[m_act]) t_ph = P_IDLE;
            end else begin
                if (t_wr && t_idx == 2'd3) begin
                    t_ph = P_IDLE;
                    t_clr[m_act] = 1'b1;
                end else if (!in_kernel) begin
                    t_ph = P_IDLE;
                end
            end
            if (t_wr && t_idx == 2'd0) t_clr = t_clr | wdata[3:0];
            m_pend  <= EDGE ? ((m_pend & ~t_clr) | (src & ~m_src_q)) : 4'b0;
            m_src_q <= src;
            if (t_wr && t_idx == 2'd1) m_mask <= wdata[3:0];
            m_phase <= t_ph;
            m_act   <= t_act;
            m_irq   <= (t_ph == P_REQ);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge sysclk) begin
        #1;
        check("irq_vs_model", {31'h0, irq}, {31'h0, m_irq});
        check("rdata_vs_model", rdata, model_rdata());
    end

    // ---------------- stimulus helpers (called just after a falling edge) ----------------
    task automatic step(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] d);
        addr   = BASE_A + {28'h0, idx, 2'b00};
        wdata  = d;
        mem_wr = 1'b1;
        @(negedge sysclk);
        mem_wr = 1'b0;
        $display("[TB] write reg%0d <= %h", idx, d);
    endtask

    task automatic read_check(input string name, input logic [1:0] idx, input logic [31:0] exp);
        addr   = BASE_A + {28'h0, idx, 2'b00};
        mem_rd = 1'b1;
        #1;
        check(name, rdata, exp);
        $display("[TB] read reg%0d = %h (expect %h)", idx, rdata, exp);
        mem_rd = 1'b0;
    endtask

    task automatic irq_check(input string name, input logic exp);
        check(name, {31'h0, irq}, {31'h0, exp});
        $display("[TB] irq = %0b (expect %0b)", irq, exp);
    endtask

    initial begin
        step(3);
        irq_check("reset_irq", 1'b0);
        read_check("reset_pending", 2'd0, 32'h0);
        read_check("reset_mask", 2'd1, 32'h0);
        read_check("reset_vector", 2'd2, 32'h0);
        reset = 1'b1;
        step(2);

        // Basic request / service / EOI on source 1
        bus_write(2'd1, 32'h3);
        read_check("mask_rw", 2'd1, 32'h3);
        src = 4'b0010;
        step(1);
        irq_check("irq_latency_n1", 1'b0);
        step(1);
        irq_check("irq_latency_n2", 1'b1);
        in_kernel = 1'b1;
        step(1);
        irq_check("irq_in_svc", 1'b0);
        read_check("vector_svc_1", 2'd2, 32'h80000001);
        src = 4'b0000;
        step(1);
        bus_write(2'd3, 32'h0);
        in_kernel = 1'b0;
        read_check("pending_after_eoi", 2'd0, 32'h0);
        read_check("vector_after_eoi", 2'd2, 32'h0);
        read_check("eoi_reads_zero", 2'd3, 32'h0);

        // Simultaneous sources 0 and 2: 0 wins, then 2 after EOI
        bus_write(2'd1, 32'h5);
        src = 4'b0101;
        step(2);
        irq_check("two_src_irq", 1'b1);
        in_kernel = 1'b1;
        step(1);
        read_check("vector_winner_0", 2'd2, 32'h80000000);
        src = 4'b0100;
        step(2);
        in_kernel = 1'b0;
        bus_write(2'd3, 32'h0);
        irq_check("idle_after_eoi", 1'b0);
        step(1);
        irq_check("rerequest_src2", 1'b1);
        in_kernel = 1'b1;
        step(1);
        read_check("vector_winner_2", 2'd2, 32'h80000002);
        src = 4'b0000;
        step(2);
        in_kernel = 1'b0;
        bus_write(2'd3, 32'h0);
        step(3);
        irq_check("quiet_after_src2", 1'b0);
        read_check("pending_clear_2", 2'd0, 32'h0);

        // Withdraw by masking while in REQ
        bus_write(2'd1, 32'h3);
        src = 4'b0010;
        step(2);
        irq_check("req_before_mask", 1'b1);
        bus_write(2'd1, 32'h0);
        irq_check("req_holds_one_edge", 1'b1);
        step(1);
        irq_check("withdrawn_irq", 1'b0);
        read_check("pending_kept", 2'd0, 32'h2);
        src = 4'b0000;
        bus_write(2'd0, 32'h2);
        step(2);
        read_check("pending_w1c", 2'd0, 32'h0);

        // No preemption during SVC
        bus_write(2'd1, 32'h3);
        src = 4'b0010;
        step(2);
        in_kernel = 1'b1;
        step(1);
        read_check("vector_svc_1b", 2'd2, 32'h80000001);
        src = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step(1);
            irq_check("no_preempt", 1'b0);
        end
        src = 4'b0001;
        step(2);
        in_kernel = 1'b0;
        bus_write(2'd3, 32'h0);
        step(1);
        irq_check("preempt_after_eoi", 1'b1);
        in_kernel = 1'b1;
        step(1);
        read_check("vector_after_preempt", 2'd2, 32'h80000000);
        src = 4'b0000;
        step(2);
        in_kernel = 1'b0;
        bus_write(2'd3, 32'h0);
        step(3);
        read_check("pending_clear_4", 2'd0, 32'h0);

        // Set wins over same-cycle W1C
        bus_write(2'd1, 32'h0);
        src = 4'b0001;
        bus_write(2'd0, 32'h1);
        read_check("set_wins", 2'd0, 32'h1);
        bus_write(2'd0, 32'h1);
        read_check("w1c_no_edge", 2'd0, EDGE ? 32'h0 : 32'h1);
        src = 4'b0000;
        step(2);
        read_check("pending_clear_5", 2'd0, 32'h0);

        // Out-of-window read
        addr = 32'h40000020;
        mem_rd = 1'b1;
        #1;
        check("unselected_read", rdata, 32'h0);
        mem_rd = 1'b0;

        // Asynchronous reset while in SVC
        bus_write(2'd1, 32'h1);
        src = 4'b0001;
        step(2);
        irq_check("pre_reset_req", 1'b1);
        in_kernel = 1'b1;
        step(1);
        read_check("pre_reset_vector", 2'd2, 32'h80000000);
        #2;
        reset = 1'b0;
        #1;
        irq_check("async_reset_irq", 1'b0);
        read_check("async_reset_mask", 2'd1, 32'h0);
        read_check("async_reset_pending", 2'd0, 32'h0);
        read_check("async_reset_vector", 2'd2, 32'h0);
        src = 4'b0000;
        in_kernel = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
        irq_check("post_reset_irq", 1'b0);
        read_check("post_reset_mask", 2'd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
